refill_arbiter: RTL and testbench

- Shares the single AXI read channel between the instruction-cache and data-cache line-refill requests.
- Grants one requester at a time and issues one INCR burst per refill.
- Collects the beats into a line buffer, then pulses a grant to the owning cache with the full line.
- Sits between both caches' miss FSMs (SWAP_IN state) and the AXI master interface.

---
 rtl/refill_arbiter.sv | 124 ++++++++++++
 tb/tb_refill_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/refill_arbiter.sv
// Arbitrates the single AXI read channel between icache and dcache line refills.
// Optional macro REFILL_ARBITER_ROUND_ROBIN_EN: alternate winners on ties instead of dcache priority.
module refill_arbiter #(
    parameter int OFFSET_LEN = 5,
    parameter int ADDR_W     = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_req,
    input  logic [ADDR_W-1:0]                      i_addr,
    output logic                                   i_gnt,
    input  logic                                   d_req,
    input  logic [ADDR_W-1:0]                      d_addr,
    output logic                                   d_gnt,
    output logic [32*(1<<(OFFSET_LEN-2))-1:0]      line_data,
    output logic                                   busy,
    output logic                                   arvalid,
    output logic [ADDR_W-1:0]                      araddr,
    output logic [7:0]                             arlen,
    input  logic                                   arready,
    input  logic                                   rvalid,
    input  logic [31:0]                            rdata,
    input  logic                                   rlast,
    output logic                                   rready
);

    localparam int WPL   = 1 << (OFFSET_LEN - 2);
    localparam int CNT_W = (OFFSET_LEN > 2) ? OFFSET_LEN - 2 : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WPL - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_LEN;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   owner_d;
    logic                   pick_d;
    logic                   any_req;
    logic [ADDR_W-1:0]      addr_q;
    logic [CNT_W-1:0]       cnt;
    logic [WPL-1:0][31:0]   line_q;

    assign any_req = i_req | d_req;

`ifdef REFILL_ARBITER_ROUND_ROBIN_EN
    // last_d remembers who was served last so a tie goes to the other cache
    logic last_d;

    assign pick_d = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ADDR;
            ADDR:    if (arready) state_next = DATA;
            DATA:    if (rvalid && rlast) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Owner and line address are frozen at the IDLE decision; beats past the last word overwrite it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d <= 1'b0;
            addr_q  <= '0;
            cnt     <= '0;
            line_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= pick_d;
                        addr_q  <= (pick_d ? d_addr : i_addr) & LINE_MASK;
                    end
                end
                ADDR: begin
                    if (arready) cnt <= '0;
                end
                DATA: begin
                    if (rvalid) begin
                        line_q[cnt] <= rdata;
                        if (cnt != LAST_WORD) cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arvalid   = (state == ADDR);
    assign rready    = (state == DATA);
    assign busy      = (state != IDLE);
    assign i_gnt     = (state == DONE) && !owner_d;
    assign d_gnt     = (state == DONE) && owner_d;
    assign araddr    = addr_q;
    assign arlen     = 8'(WPL - 1);
    assign line_data = line_q;

endmodule

// File: tb/tb_refill_arbiter.sv
// Self-checking bench for refill_arbiter: the bench plays both caches and the AXI memory,
// and predicts each granted line from the beats it handed out.
module tb_refill_arbiter;

    localparam int OFFSET_LEN = 5;
    localparam int ADDR_W     = 32;
    localparam int WPL        = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_req, d_req;
    logic [ADDR_W-1:0]    i_addr, d_addr;
    logic                 i_gnt, d_gnt;
    logic [32*WPL-1:0]    line_data;
    logic                 busy, arvalid, arready, rvalid, rlast, rready;
    logic [ADDR_W-1:0]    araddr;
    logic [7:0]           arlen;
    logic [31:0]          rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_line [WPL];
    int          pend_i, pend_d;
    bit          drop_i, drop_d;

    always #5 clk = ~clk;

    refill_arbiter #(.OFFSET_LEN(OFFSET_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .line_data(line_data), .busy(busy),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        i_req = (pend_i > 0) && !drop_i;
        d_req = (pend_d > 0) && !drop_d;
    endtask

    task automatic check_line(input string tag);
        for (int k = 0; k < WPL; k++)
            checkOutput($sformatf("%s_w%0d", tag, k), line_data[32*k +: 32], model_line[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend_i = 0; pend_d = 0; drop_i = 0; drop_d = 0;
        drive_reqs();
        arready = 0; rvalid = 0; rlast = 0; rdata = '0;
        for (int k = 0; k < WPL; k++) model_line[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rst_rready",  32'(rready),  32'd0);
        checkOutput("rst_gnt",     32'({i_gnt, d_gnt}), 32'd0);
        checkOutput("rst_araddr",  araddr, 32'd0);
        check_line("rst_line");
        rst = 1'b0;
    endtask

    // One refill from an IDLE cycle to the cycle after its grant. gap<0 means random beat gaps,
    // data_base!=0 gives beat n the value data_base+n, abort_at>0 resets after that many beats.
    task automatic applyStimulus(input bit exp_d, input int ar_wait, input int gap, input int last_at,
                                 input bit disturb, input int abort_at, input logic [31:0] data_base);
        logic [31:0] exp_addr;
        int cyc = 0, ar_cnt = 0, beat = 0, widx = 0, gap_left = 0;
        bit done = 0, seen_ar = 0;
        exp_addr = (exp_d ? d_addr : i_addr) & 32'hFFFF_FFE0;
        drive_reqs();
        while (!done && cyc < 300) begin
            if (cyc == 0) checkOutput("idle_busy", 32'(busy), 32'd0);
            if (cyc == 1) checkOutput("run_busy",  32'(busy), 32'd1);
            if (i_gnt || d_gnt) begin
                checkOutput("gnt_owner_d", 32'(d_gnt), 32'(exp_d));
                checkOutput("gnt_owner_i", 32'(i_gnt), 32'(!exp_d));
                checkOutput("gnt_after_rlast", 32'(beat >= last_at), 32'd1);
                check_line("gnt_line");
                if (ar_wait == 0 && gap == 0 && last_at == WPL)
                    checkOutput("gnt_latency", 32'(cyc), 32'd10);
                if (exp_d) begin pend_d--; drop_d = 0; end
                else       begin pend_i--; drop_i = 0; end
                drive_reqs();
                arready = 0; rvalid = 0; rlast = 0;
                done = 1;
            end else begin
                if (arvalid) begin
                    if (!seen_ar) begin
                        checkOutput("ar_rise_cycle", 32'(cyc), 32'd1);
                        checkOutput("arlen", 32'(arlen), 32'd7);
                        seen_ar = 1;
                    end
                    checkOutput("araddr", araddr, exp_addr);
                    arready = (ar_cnt >= ar_wait);
                    ar_cnt++;
                end else begin
                    arready = 1'($urandom_range(0, 1));
                end
                if (rready && abort_at > 0 && beat == abort_at) begin
                    #2 rst = 1'b1;
                    #1;
                    checkOutput("abort_rready", 32'(rready), 32'd0);
                    checkOutput("abort_busy",   32'(busy),   32'd0);
                    checkOutput("abort_gnt",    32'({i_gnt, d_gnt}), 32'd0);
                    checkOutput("abort_word0",  line_data[31:0], 32'd0);
                    pend_i = 0; pend_d = 0; drop_i = 0; drop_d = 0;
                    drive_reqs();
                    arready = 0; rvalid = 0; rlast = 0;
                    for (int k = 0; k < WPL; k++) model_line[k] = '0;
                    done = 1;
                end else if (rready) begin
                    if (gap_left > 0) begin
                        rvalid = 0; rlast = 0;
                        gap_left--;
                    end else begin
                        rvalid = 1;
                        rdata  = (data_base != 0) ? data_base + 32'(beat) : $urandom;
                        rlast  = (beat == last_at - 1);
                        model_line[widx] = rdata;
                        if (widx < WPL - 1) widx++;
                        beat++;
                        gap_left = (gap < 0) ? $urandom_range(0, 2) : gap;
                    end
                end else begin
                    rvalid = 0; rlast = 0;
                end
                if (disturb && cyc == 2) begin
                    if (exp_d) begin d_addr = $urandom; drop_d = 1; end
                    else       begin i_addr = $urandom; drop_i = 1; end
                    drive_reqs();
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done) rst = 1'b0;
        end
        if (!done) checkOutput("refill_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        i_addr = '0; d_addr = '0;
        do_reset();

        // single icache refill with a known pattern
        i_addr = 32'h1FC0_0014; pend_i = 1;
        applyStimulus(0, 0, 0, 8, 0, 0, 32'hA0);

        // contention: dcache first, icache in the following burst
        i_addr = 32'h0000_4444; d_addr = 32'h8000_1234; pend_i = 1; pend_d = 1;
        applyStimulus(1, 0, 0, 8, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 8, 0, 0, 32'h0);

        // address stall and spaced beats
        d_addr = $urandom; pend_d = 1;
        applyStimulus(1, 5, 2, 8, 0, 0, 32'h0);

        // early rlast, then extra beats saturating on the last word
        i_addr = $urandom; pend_i = 1;
        applyStimulus(0, 0, 0, 3, 0, 0, 32'h0);
        d_addr = $urandom; pend_d = 1;
        applyStimulus(1, 0, 1, 10, 0, 0, 32'h0);

        // owner drops req and changes address after the latch
        i_addr = $urandom; pend_i = 1;
        applyStimulus(0, 2, 0, 8, 1, 0, 32'h0);

        for (int n = 0; n < 6; n++) begin
            bit use_d;
            use_d = 1'($urandom_range(0, 1));
            if (use_d) begin d_addr = $urandom; pend_d = 1; end
            else       begin i_addr = $urandom; pend_i = 1; end
            applyStimulus(use_d, $urandom_range(0, 3), -1, $urandom_range(1, 10), 0, 0, 32'h0);
        end

        // reset in the middle of the data phase, then a clean refill
        i_addr = 32'h0000_2000; pend_i = 1;
        applyStimulus(0, 0, 0, 8, 0, 4, 32'h0);
        i_addr = 32'h0000_3008; pend_i = 1;
        applyStimulus(0, 0, 0, 8, 0, 0, 32'h0);

        // arbitration order under continuous contention
        do_reset();
        i_addr = 32'h0001_0000; d_addr = 32'h0002_0000;
`ifdef REFILL_ARBITER_ROUND_ROBIN_EN
        pend_i = 2; pend_d = 2;
        applyStimulus(1, 0, 0, 8, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 8, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 8, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 8, 0, 0, 32'h0);
`else
        pend_i = 1; pend_d = 4;
        for (int n = 0; n < 4; n++) applyStimulus(1, 0, 0, 8, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 8, 0, 0, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
